// File: rtl/msix_gen_pkg.sv
// Shared widths, FSM state encoding and message payload for the MSI-X generator.
package msix_gen_pkg;

  localparam int unsigned U64   = 64;
  localparam int unsigned U32   = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } msix_state_e;

  // One vector table entry / one outgoing host write.
  typedef struct packed {
    logic [U64-1:0] addr;
    logic [U32-1:0] data;
  } msix_msg_t;

endpackage

// File: rtl/msix_gen_if.sv
// Host dword-write port: valid/ready handshake with 64-bit address and 32-bit data.
interface msix_gen_if;

  logic                           wr_valid;
  logic                           wr_ready;
  logic [msix_gen_pkg::U64-1:0]   wr_addr;
  logic [msix_gen_pkg::U32-1:0]   wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/msix_gen_rr_arb.sv
// Combinational round-robin picker: first requesting index after the last grant.
module msix_rr_arb #(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned VEC_W   = $clog2(NUM_VEC)
) (
  input  logic [NUM_VEC-1:0] req,
  input  logic [VEC_W-1:0]   last,
  output logic [VEC_W-1:0]   gnt_c,
  output logic               gnt_valid_c
);

  logic [VEC_W-1:0] idx;

  // Scan last+1 .. last+NUM_VEC (mod NUM_VEC); the first hit wins.
  always_comb begin
    gnt_c       = '0;
    gnt_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned i = 1; i <= NUM_VEC; i++) begin
      idx = VEC_W'((32'(last) + i) % NUM_VEC);
      if (!gnt_valid_c && req[idx]) begin
        gnt_c       = idx;
        gnt_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msix_gen.sv
// MSI-X message generator: vector table, pending bit array, round-robin send FSM.
module msix_gen
  import msix_gen_pkg::*;
#(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned VEC_W   = $clog2(NUM_VEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [VEC_W-1:0]   cfg_vec,
  input  logic [U64-1:0]     cfg_addr,
  input  logic [U32-1:0]     cfg_data,
  input  logic               cfg_mask,
  input  logic               func_mask,
  input  logic [NUM_VEC-1:0] irq_req,
  msix_gen_if.master         wr_if,
  output logic [NUM_VEC-1:0] pending,
  output logic [CNT_W-1:0]   sent_cnt
);

  msix_state_e        state_q, state_d;
  msix_msg_t          tbl_q [NUM_VEC];
  logic [NUM_VEC-1:0] mask_q;
  logic [NUM_VEC-1:0] pend_q;
  logic [NUM_VEC-1:0] elig_c;
  logic [NUM_VEC-1:0] clr_c;
  logic [VEC_W-1:0]   rr_q;
  logic [VEC_W-1:0]   gnt_c;
  logic               gnt_valid_c;
  logic               grant_c;
  logic               accept_c;
  msix_msg_t          msg_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;

  assign elig_c = pend_q & ~mask_q & {NUM_VEC{~func_mask}};

  msix_rr_arb #(.NUM_VEC(NUM_VEC), .VEC_W(VEC_W)) u_arb (
    .req         (elig_c),
    .last        (rr_q),
    .gnt_c       (gnt_c),
    .gnt_valid_c (gnt_valid_c)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    grant_c  = 1'b0;
    accept_c = 1'b0;
    clr_c    = '0;
    case (state_q)
      ST_IDLE: if (|elig_c) state_d = ST_ARB;
      ST_ARB: begin
        if (gnt_valid_c) begin
          state_d = ST_SEND;
          grant_c = 1'b1;
          clr_c   = NUM_VEC'(1) << gnt_c;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (wr_if.wr_ready) begin
          state_d  = ST_IDLE;
          accept_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Vector table: address/data/mask per entry, masks set out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) tbl_q[i] <= '0;
      mask_q <= '1;
    end else if (cfg_we && (32'(cfg_vec) < NUM_VEC)) begin
      tbl_q[cfg_vec]  <= '{addr: cfg_addr, data: cfg_data};
      mask_q[cfg_vec] <= cfg_mask;
    end
  end

  // Pending bits: a new request wins over the grant clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= (pend_q & ~clr_c) | irq_req;
  end

  // Output message register, round-robin pointer and accepted-message counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      msg_q   <= '0;
      rr_q    <= VEC_W'(NUM_VEC - 1);
      cnt_q   <= '0;
    end else if (grant_c) begin
      valid_q <= 1'b1;
      msg_q   <= tbl_q[gnt_c];
      rr_q    <= gnt_c;
    end else if (accept_c) begin
      valid_q <= 1'b0;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign wr_if.wr_valid = valid_q;
  assign wr_if.wr_addr  = msg_q.addr;
  assign wr_if.wr_data  = msg_q.data;
  assign pending        = pend_q;
  assign sent_cnt       = cnt_q;

endmodule

// File: tb/tb_msix_gen.sv
// Directed bench for msix_gen with a host-side write monitor.
module tb_msix_gen;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_vec;
  logic [63:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_mask;
  logic        func_mask;
  logic [7:0]  irq_req;
  logic [7:0]  pending;
  logic [15:0] sent_cnt;

  msix_gen_if wr_if ();

  msix_gen #(.NUM_VEC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_vec   (cfg_vec),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_mask  (cfg_mask),
    .func_mask (func_mask),
    .irq_req   (irq_req),
    .wr_if     (wr_if),
    .pending   (pending),
    .sent_cnt  (sent_cnt)
  );

  typedef struct {
    logic [7:0]  irq;
    int unsigned n;
    logic [2:0]  ord [3];
  } rr_vec_t;

  rr_vec_t     rr_tbl [7];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          qbase    = 0;
  int          irq_base = 0;
  int          host_irq_cnt = 0;
  logic [63:0] q_addr [$];
  logic [31:0] q_data [$];
  bit          ok;
  int          exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host model: record every accepted write as an MSI-X interrupt.
  always @(negedge clk) begin
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      q_addr.push_back(wr_if.wr_addr);
      q_data.push_back(wr_if.wr_data);
      host_irq_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] exp_addr(input int unsigned v);
    return 64'hFEE0_0000 + 64'(v) * 64'h10;
  endfunction

  function automatic logic [31:0] exp_data(input int unsigned v);
    return 32'hD000_0000 + 32'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    qbase    = q_addr.size();
    irq_base = host_irq_cnt;
  endtask

  task automatic cfg_write(input logic [2:0] v, input logic [63:0] a,
                           input logic [31:0] d, input logic m);
    cfg_we   = 1'b1;
    cfg_vec  = v;
    cfg_addr = a;
    cfg_data = d;
    cfg_mask = m;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_req = v;
    tick();
    irq_req = 8'h00;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_if.wr_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic int n_writes();
    return q_addr.size() - qbase;
  endfunction

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_vec = '0; cfg_addr = '0; cfg_data = '0;
    cfg_mask = 1'b1; func_mask = 1'b0; irq_req = '0; wr_if.wr_ready = 1'b1;

    // Round-robin patterns applied after the all-vector run leaves the pointer at 7.
    rr_tbl[0] = '{irq: 8'h05, n: 2, ord: '{3'd0, 3'd2, 3'd0}};
    rr_tbl[1] = '{irq: 8'h07, n: 3, ord: '{3'd0, 3'd1, 3'd2}};
    rr_tbl[2] = '{irq: 8'h88, n: 2, ord: '{3'd3, 3'd7, 3'd0}};
    rr_tbl[3] = '{irq: 8'h81, n: 2, ord: '{3'd0, 3'd7, 3'd0}};
    rr_tbl[4] = '{irq: 8'h42, n: 2, ord: '{3'd1, 3'd6, 3'd0}};
    rr_tbl[5] = '{irq: 8'hC0, n: 2, ord: '{3'd7, 3'd6, 3'd0}};
    rr_tbl[6] = '{irq: 8'h11, n: 2, ord: '{3'd0, 3'd4, 3'd0}};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_wr_valid", 64'(wr_if.wr_valid), 64'h0);
    chk("rst_wr_addr",  wr_if.wr_addr,       64'h0);
    chk("rst_wr_data",  64'(wr_if.wr_data),  64'h0);
    chk("rst_pending",  64'(pending),        64'h0);
    chk("rst_sent_cnt", 64'(sent_cnt),       64'h0);
    tick();

    // Single vector, latency N+3
    cfg_write(3'd0, 64'h1, 32'h1234_5678, 1'b0);
    pulse(8'h01);
    @(negedge clk); chk("lat_n1_valid", 64'(wr_if.wr_valid), 64'h0);
    @(negedge clk); chk("lat_n2_valid", 64'(wr_if.wr_valid), 64'h0);
    @(negedge clk); chk("lat_n3_valid", 64'(wr_if.wr_valid), 64'h1);
    chk("lat_addr", wr_if.wr_addr, 64'h1);
    chk("lat_data", 64'(wr_if.wr_data), 64'h1234_5678);
    tick();
    chk("single_sent_cnt", 64'(sent_cnt), 64'h1);
    chk("single_valid_drop", 64'(wr_if.wr_valid), 64'h0);
    chk("single_host_irq", 64'(host_irq_cnt - irq_base), 64'h1);
    chk("single_pending", 64'(pending), 64'h0);

    // Two simultaneous requests: vec0 then vec2
    do_reset();
    cfg_write(3'd0, exp_addr(0), exp_data(0), 1'b0);
    cfg_write(3'd2, exp_addr(2), exp_data(2), 1'b0);
    pulse(8'h05);
    repeat (12) tick();
    chk("pair_count", 64'(n_writes()), 64'h2);
    if (n_writes() >= 2) begin
      chk("pair_first",  q_addr[qbase],     exp_addr(0));
      chk("pair_second", q_addr[qbase + 1], exp_addr(2));
    end
    chk("pair_pending", 64'(pending), 64'h0);
    chk("pair_sent_cnt", 64'(sent_cnt), 64'h2);

    // Masked vector coalesces and sends once after unmask
    do_reset();
    cfg_write(3'd3, 64'hAAAA_0000_0000_0030, 32'h3333_3333, 1'b1);
    pulse(8'h08); tick();
    pulse(8'h08); tick();
    pulse(8'h08);
    repeat (10) tick();
    chk("mask_no_write", 64'(n_writes()), 64'h0);
    chk("mask_pending", 64'(pending), 64'h08);
    cfg_write(3'd3, 64'hAAAA_0000_0000_0030, 32'h3333_3333, 1'b0);
    repeat (10) tick();
    chk("unmask_count", 64'(n_writes()), 64'h1);
    if (n_writes() >= 1) chk("unmask_addr", q_addr[qbase], 64'hAAAA_0000_0000_0030);
    chk("unmask_pending", 64'(pending), 64'h0);

    // Backpressure with table rewrite and re-request of the in-flight vector
    do_reset();
    cfg_write(3'd0, 64'h0000_0001_0000_0100, 32'h0BAD_F00D, 1'b0);
    wr_if.wr_ready = 1'b0;
    pulse(8'h01);
    wait_valid(10, ok);
    chk("bp_wait_valid", 64'(ok), 64'h1);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        cfg_we = 1'b1; cfg_vec = 3'd0; cfg_mask = 1'b0;
        cfg_addr = 64'h0000_0002_0000_0200; cfg_data = 32'h600D_CAFE;
      end
      if (c == 1) begin
        cfg_we = 1'b0; irq_req = 8'h01;
      end
      if (c == 2) irq_req = 8'h00;
      @(negedge clk);
      chk("bp_hold_valid", 64'(wr_if.wr_valid), 64'h1);
      chk("bp_hold_addr",  wr_if.wr_addr, 64'h0000_0001_0000_0100);
      chk("bp_hold_data",  64'(wr_if.wr_data), 64'h0BAD_F00D);
      if (c == 9) chk("bp_repend", 64'(pending), 64'h01);
    end
    tick();
    wr_if.wr_ready = 1'b1;
    repeat (15) tick();
    chk("bp_count", 64'(n_writes()), 64'h2);
    if (n_writes() >= 2) begin
      chk("bp_first_addr",  q_addr[qbase],          64'h0000_0001_0000_0100);
      chk("bp_second_addr", q_addr[qbase + 1],      64'h0000_0002_0000_0200);
      chk("bp_second_data", 64'(q_data[qbase + 1]), 64'h600D_CAFE);
    end
    chk("bp_sent_cnt", 64'(sent_cnt), 64'h2);

    // Same-cycle table write and request
    do_reset();
    cfg_we = 1'b1; cfg_vec = 3'd5; cfg_mask = 1'b0;
    cfg_addr = 64'hCAFE_0000_0000_0040; cfg_data = 32'h5555_AAAA;
    irq_req = 8'h20;
    tick();
    cfg_we = 1'b0; irq_req = 8'h00;
    repeat (8) tick();
    chk("same_cyc_count", 64'(n_writes()), 64'h1);
    if (n_writes() >= 1) begin
      chk("same_cyc_addr", q_addr[qbase], 64'hCAFE_0000_0000_0040);
      chk("same_cyc_data", 64'(q_data[qbase]), 64'h5555_AAAA);
    end

    // Reset during SEND discards the message
    do_reset();
    cfg_write(3'd0, 64'h77, 32'h77, 1'b0);
    wr_if.wr_ready = 1'b0;
    pulse(8'h01);
    wait_valid(10, ok);
    chk("rsend_wait_valid", 64'(ok), 64'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rsend_valid",   64'(wr_if.wr_valid), 64'h0);
    chk("rsend_addr",    wr_if.wr_addr, 64'h0);
    chk("rsend_data",    64'(wr_if.wr_data), 64'h0);
    chk("rsend_pending", 64'(pending), 64'h0);
    chk("rsend_cnt",     64'(sent_cnt), 64'h0);
    tick();
    wr_if.wr_ready = 1'b1;
    qbase = q_addr.size();
    repeat (10) tick();
    chk("rsend_no_msg", 64'(n_writes()), 64'h0);

    // Function mask holds all vectors, release sends all in order
    do_reset();
    for (int i = 0; i < 8; i++) cfg_write(3'(i), exp_addr(32'(i)), exp_data(32'(i)), 1'b0);
    func_mask = 1'b1;
    pulse(8'hFF);
    repeat (10) tick();
    chk("fmask_no_write", 64'(n_writes()), 64'h0);
    chk("fmask_pending",  64'(pending), 64'hFF);
    func_mask = 1'b0;
    repeat (45) tick();
    chk("fmask_count", 64'(n_writes()), 64'h8);
    for (int k = 0; k < 8; k++) begin
      if (k < n_writes()) begin
        chk("fmask_order_addr", q_addr[qbase + k], exp_addr(32'(k)));
        chk("fmask_order_data", 64'(q_data[qbase + k]), 64'(exp_data(32'(k))));
      end
    end
    exp_cnt = 8;

    // Table-driven round-robin patterns
    for (int r = 0; r < 7; r++) begin
      qbase = q_addr.size();
      pulse(rr_tbl[r].irq);
      repeat (15) tick();
      exp_cnt += int'(rr_tbl[r].n);
      chk("rr_count", 64'(n_writes()), 64'(rr_tbl[r].n));
      for (int k = 0; k < int'(rr_tbl[r].n); k++) begin
        if (k < n_writes()) begin
          chk("rr_order_addr", q_addr[qbase + k], exp_addr(32'(rr_tbl[r].ord[k])));
          chk("rr_order_data", 64'(q_data[qbase + k]), 64'(exp_data(32'(rr_tbl[r].ord[k]))));
        end
      end
      chk("rr_pending",  64'(pending), 64'h0);
      chk("rr_sent_cnt", 64'(sent_cnt), 64'(exp_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msix_gen.md
MSIX_GEN -- requirements
Module: msix_gen

Interface
REQ-001 SHALL have parameter NUM_VEC, default 8, number of MSI-X vectors (2..32).
REQ-002 SHALL have parameter VEC_W, default $clog2(NUM_VEC), vector index width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_we  input  1  vector table entry write strobe.
REQ-006 SHALL have port cfg_vec  input  VEC_W  table entry index.
REQ-007 SHALL have port cfg_addr  input  64  message address for the entry.
REQ-008 SHALL have port cfg_data  input  32  message data for the entry.
REQ-009 SHALL have port cfg_mask  input  1  per-vector mask bit for the entry.
REQ-010 SHALL have port func_mask  input  1  global function mask; blocks all sends.
REQ-011 SHALL have port irq_req  input  NUM_VEC  one-cycle interrupt request pulses, one bit per vector.
REQ-012 SHALL have port wr_valid  output  1  dword write to host memory valid.
REQ-013 SHALL have port wr_ready  input  1  host write port accepts.
REQ-014 SHALL have port wr_addr  output  64  host write address.
REQ-015 SHALL have port wr_data  output  32  host write dword.
REQ-016 SHALL have port pending  output  NUM_VEC  pending bit array (PBA).
REQ-017 SHALL have port sent_cnt  output  16  count of accepted messages.

Function
REQ-018 SHALL set pending[i] on irq_req[i]; repeat requests while pending[i] is set coalesce into one message.
REQ-019 SHALL run FSM IDLE -> ARB -> SEND -> IDLE.
REQ-020 SHALL leave IDLE for ARB when any pending[i] has cfg_mask[i]=0 and func_mask=0 (eligible).
REQ-021 ARB SHALL pick the eligible vector round-robin, starting from last granted index +1 (wraps NUM_VEC-1 -> 0), clear its pending bit, latch its addr/data into the output registers, and go to SEND.
REQ-022 ARB SHALL return to IDLE without a grant if eligibility was lost that cycle (mask set).
REQ-023 In SEND, wr_valid SHALL be 1 with wr_addr/wr_data stable until wr_ready=1, then return to IDLE; sent_cnt SHALL increment by 1 in the same cycle, wrapping at 0xFFFF -> 0.
REQ-024 Latency: an irq_req pulse at cycle N in IDLE with no contention SHALL give wr_valid=1 at cycle N+3.
REQ-025 A request for the vector currently in SEND SHALL set its pending bit again and produce a second message later.
REQ-026 A table write (cfg_we) to the vector currently in SEND SHALL NOT change wr_addr/wr_data of the in-flight message.
REQ-027 When cfg_we and irq_req target the same vector in one cycle, both SHALL take effect; the new table values apply to the resulting message.
REQ-028 Masked vectors SHALL keep their pending bit and SHALL be sent after unmask; setting a mask SHALL NOT abort a message already in SEND.
REQ-029 Arbitration and FSM progress SHALL be independent of wr_ready except in SEND.

Reset
REQ-030 On rst: FSM=IDLE, wr_valid=0, wr_addr=0, wr_data=0, pending=0, sent_cnt=0, round-robin pointer=NUM_VEC-1 (vector 0 first), all table masks=1, table addr/data=0.
REQ-031 Reset asserted during SEND SHALL drop wr_valid in the next cycle; the message SHALL be discarded without retry.

Structure
REQ-032 The shared misc package SHALL hold U64/U32 usage and the FSM state enum (msix_state_e); widths SHALL come from it.
REQ-033 The round-robin arbiter SHALL be one sub-module, msix_rr_arb (req vector, last grant in; grant index and valid out).

Verification
REQ-034 Table vec0 = {0x1, 0x12345678, unmasked}; pulse irq_req[0] -> one write addr 0x1 data 0x12345678 at N+3; the host model flags an MSI-X interrupt; sent_cnt=1.
REQ-035 Pulse irq_req 0x05 together -> vec0 then vec2, in that order; pending=0 after both; sent_cnt=2.
REQ-036 Vec3 masked, pulse irq_req[3] three times -> no write; pending[3]=1; unmask -> exactly one write.
REQ-037 Hold wr_ready=0 for 10 cycles in SEND, while also rewriting the vec0 entry and pulsing irq_req[0] -> output held stable, then a second message with the new values.
REQ-038 Assert rst in SEND -> wr_valid=0 next cycle; all outputs and pending at reset values; no message emitted afterwards.
REQ-039 func_mask=1 with all vectors pending -> no writes; clear func_mask -> NUM_VEC writes in round-robin order.
